// File: rtl/exe_stage.sv
// +--------------------------------------------------------------------------+
// | exe_stage : ALU, branch resolution, shift-add multiplier, EXE/MEM reg    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dest_in,
  input  logic [31:0] val1,
  input  logic [31:0] reg2,
  input  logic [31:0] val2,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic [1:0]  mem_signal_in,
  input  logic [1:0]  branch_type_in,
  input  logic [3:0]  exe_cmd_in,
  output logic        br_taken,
  output logic [31:0] br_addr,
  output logic        stall,
  output logic [4:0]  dest_out,
  output logic [31:0] alu_result,
  output logic [31:0] st_val,
  output logic        wb_en_out,
  output logic [1:0]  mem_signal_out
);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  mul_state_t  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [4:0]  dest_q, dest_d;
  logic [31:0] result_q, result_d;
  logic [31:0] st_val_q, st_val_d;
  logic        wb_en_q, wb_en_d;
  logic [1:0]  mem_signal_q, mem_signal_d;

  logic        is_mul;
  logic [31:0] alu_out;
  logic [4:0]  shamt;

  assign is_mul = (exe_cmd_in == CMD_MUL);
  assign shamt  = val2[4:0];

  always_comb begin
    alu_out = 32'h0;
    case (exe_cmd_in)
      CMD_ADD: alu_out = val1 + val2;
      CMD_SUB: alu_out = val1 - val2;
      CMD_AND: alu_out = val1 & val2;
      CMD_OR:  alu_out = val1 | val2;
      CMD_NOR: alu_out = ~(val1 | val2);
      CMD_XOR: alu_out = val1 ^ val2;
      CMD_SLL: alu_out = val1 << shamt;
      CMD_SRA: alu_out = $signed(val1) >>> shamt;
      CMD_SRL: alu_out = val1 >> shamt;
      default: alu_out = 32'h0;
    endcase
  end

  // Target is computed for every branch type so IF can use it without decoding.
  always_comb begin
    br_addr  = pc_in + {val2[29:0], 2'b00};
    br_taken = 1'b0;
    case (branch_type_in)
      BR_NONE: br_taken = 1'b0;
      BR_BEZ:  br_taken = (val1 == 32'h0);
      BR_BNE:  br_taken = (val1 != reg2);
      BR_JMP:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          mcand_d  = val1;
          mplier_d = val2;
          acc_d    = 32'h0;
          cnt_d    = 5'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE is the one cycle a MUL is allowed through; the product is acc_q then.
  assign stall = is_mul && (state_q != DONE);

  always_comb begin
    dest_d       = 5'd0;
    result_d     = 32'h0;
    st_val_d     = 32'h0;
    wb_en_d      = 1'b0;
    mem_signal_d = 2'b00;
    if (!stall) begin
      dest_d       = dest_in;
      result_d     = (state_q == DONE) ? acc_q : alu_out;
      st_val_d     = reg2;
      wb_en_d      = wb_en_in;
      mem_signal_d = mem_signal_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mcand_q      <= 32'h0;
      mplier_q     <= 32'h0;
      acc_q        <= 32'h0;
      cnt_q        <= 5'd0;
      dest_q       <= 5'd0;
      result_q     <= 32'h0;
      st_val_q     <= 32'h0;
      wb_en_q      <= 1'b0;
      mem_signal_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dest_q       <= dest_d;
      result_q     <= result_d;
      st_val_q     <= st_val_d;
      wb_en_q      <= wb_en_d;
      mem_signal_q <= mem_signal_d;
    end
  end

  assign dest_out       = dest_q;
  assign alu_result     = result_q;
  assign st_val         = st_val_q;
  assign wb_en_out      = wb_en_q;
  assign mem_signal_out = mem_signal_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// +--------------------------------------------------------------------------+
// | tb_exe_stage : directed self-checking bench for exe_stage                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  dest_in;
  logic [31:0] val1;
  logic [31:0] reg2;
  logic [31:0] val2;
  logic [31:0] pc_in;
  logic        wb_en_in;
  logic [1:0]  mem_signal_in;
  logic [1:0]  branch_type_in;
  logic [3:0]  exe_cmd_in;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        stall;
  logic [4:0]  dest_out;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic        wb_en_out;
  logic [1:0]  mem_signal_out;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk            (clk),
    .rst            (rst),
    .dest_in        (dest_in),
    .val1           (val1),
    .reg2           (reg2),
    .val2           (val2),
    .pc_in          (pc_in),
    .wb_en_in       (wb_en_in),
    .mem_signal_in  (mem_signal_in),
    .branch_type_in (branch_type_in),
    .exe_cmd_in     (exe_cmd_in),
    .br_taken       (br_taken),
    .br_addr        (br_addr),
    .stall          (stall),
    .dest_out       (dest_out),
    .alu_result     (alu_result),
    .st_val         (st_val),
    .wb_en_out      (wb_en_out),
    .mem_signal_out (mem_signal_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [4:0] dst, input logic wb,
                       input logic [1:0] ms, input logic [1:0] bt, input logic [31:0] pc);
    exe_cmd_in     = cmd;
    val1           = a;
    val2           = b;
    reg2           = r2;
    dest_in        = dst;
    wb_en_in       = wb;
    mem_signal_in  = ms;
    branch_type_in = bt;
    pc_in          = pc;
  endtask

  task automatic alu_step(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(cmd, a, b, 32'h0, 5'd9, 1'b1, 2'b00, 2'b00, 32'h0);
    #1;
    chk({tag, "_nostall"}, {31'h0, stall}, 32'h0);
    tick();
    chk(tag, alu_result, exp);
  endtask

  // A MUL must stall 33 cycles with a bubble each, then emit one product entry.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int  stalls;
    int  bubbles;
    bit  done;
    stalls  = 0;
    bubbles = 0;
    done    = 1'b0;
    drive(4'b1100, a, b, 32'h0, 5'd7, 1'b1, 2'b00, 2'b00, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall) begin
        stalls++;
        tick();
        if (alu_result == 32'h0 && wb_en_out == 1'b0 && dest_out == 5'd0 &&
            st_val == 32'h0 && mem_signal_out == 2'b00)
          bubbles++;
      end else begin
        done = 1'b1;
        tick();
      end
    end
    chk({tag, "_finished"}, {31'h0, done}, 32'h1);
    chk({tag, "_stall_cycles"}, stalls, 32'd33);
    chk({tag, "_bubbles"}, bubbles, 32'd33);
    chk({tag, "_product"}, alu_result, exp);
    chk({tag, "_wb_en"}, {31'h0, wb_en_out}, 32'h1);
    chk({tag, "_dest"}, {27'h0, dest_out}, 32'd7);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
          2'($urandom), 2'($urandom), $urandom);
    tick();
    drive(4'b0000, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
          2'($urandom), 2'($urandom), $urandom);
    tick();
    chk("rst_dest", {27'h0, dest_out}, 32'h0);
    chk("rst_result", alu_result, 32'h0);
    chk("rst_st_val", st_val, 32'h0);
    chk("rst_wb_en", {31'h0, wb_en_out}, 32'h0);
    chk("rst_mem_signal", {30'h0, mem_signal_out}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;

    alu_step("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    chk("add_dest", {27'h0, dest_out}, 32'd9);
    chk("add_wb_en", {31'h0, wb_en_out}, 32'h1);
    alu_step("sub_neg", 4'b0010, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_step("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_step("nor", 4'b0110, 32'h0, 32'h0, 32'hFFFF_FFFF);
    alu_step("and", 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    alu_step("or", 4'b0101, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    alu_step("xor", 4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_step("sll", 4'b1000, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030);
    alu_step("srl", 4'b1010, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_step("undef_cmd", 4'b1111, 32'h1234_5678, 32'h1, 32'h0);

    drive(4'b0000, 32'h10, 32'h20, 32'hDEAD_BEEF, 5'd17, 1'b0, 2'b01, 2'b00, 32'h0);
    tick();
    chk("store_st_val", st_val, 32'hDEAD_BEEF);
    chk("store_mem_signal", {30'h0, mem_signal_out}, 32'h1);
    chk("store_dest", {27'h0, dest_out}, 32'd17);
    chk("store_result", alu_result, 32'h30);

    drive(4'b0000, 32'h0, 32'hFFFF_FFFE, 32'h0, 5'd0, 1'b0, 2'b00, 2'b01, 32'h100);
    #1;
    chk("bez_taken", {31'h0, br_taken}, 32'h1);
    chk("bez_addr", br_addr, 32'h0000_00F8);
    val1 = 32'h1;
    #1;
    chk("bez_not_taken", {31'h0, br_taken}, 32'h0);
    drive(4'b0000, 32'd9, 32'h4, 32'd9, 5'd0, 1'b0, 2'b00, 2'b10, 32'h200);
    #1;
    chk("bne_equal", {31'h0, br_taken}, 32'h0);
    chk("bne_addr", br_addr, 32'h0000_0210);
    reg2 = 32'd8;
    #1;
    chk("bne_differ", {31'h0, br_taken}, 32'h1);
    drive(4'b0000, 32'h5, 32'h10, 32'h5, 5'd0, 1'b0, 2'b00, 2'b11, 32'h200);
    #1;
    chk("jmp_taken", {31'h0, br_taken}, 32'h1);
    chk("jmp_addr", br_addr, 32'h0000_0240);
    branch_type_in = 2'b00;
    #1;
    chk("none_not_taken", {31'h0, br_taken}, 32'h0);

    drive(4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0);
    tick();
    chk("bubble_in_result", alu_result, 32'h0);
    chk("bubble_in_wb_en", {31'h0, wb_en_out}, 32'h0);

    run_mul("mul", 32'h0001_0003, 32'h0000_0007, 32'h0007_0015);
    run_mul("mul_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    drive(4'b1100, 32'd3, 32'd5, 32'h0, 5'd7, 1'b1, 2'b00, 2'b00, 32'h0);
    repeat (11) tick();
    chk("midmul_stalling", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midmul_rst_result", alu_result, 32'h0);
    chk("midmul_rst_wb_en", {31'h0, wb_en_out}, 32'h0);
    drive(4'b0000, 32'd2, 32'd3, 32'h0, 5'd4, 1'b1, 2'b00, 2'b00, 32'h0);
    #1;
    chk("after_rst_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("after_rst_add", alu_result, 32'd5);
    chk("after_rst_dest", {27'h0, dest_out}, 32'd4);
    run_mul("mul_after_rst", 32'd3, 32'd5, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage pipelined processor. Consumes the ID/EXE pipeline-register outputs, computes the ALU result, and resolves branches for IF and the ID/EXE flush. Runs a 32-iteration shift-add multiplier with a pipeline stall, and holds the EXE/MEM pipeline register feeding the MEM stage.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- dest_in  in  5  destination register from ID/EXE.
- val1  in  32  first source operand (rs).
- reg2  in  32  raw rt value; store data and BNE compare operand.
- val2  in  32  second ALU operand: rt or sign-extended immediate.
- pc_in  in  32  PC+4 of the instruction in EXE.
- wb_en_in  in  1  write-back enable.
- mem_signal_in  in  2  {mem_r_en, mem_w_en}.
- branch_type_in  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP.
- exe_cmd_in  in  4  ALU command; encoding under Operation.
- br_taken  out  1  combinational; branch or jump taken this cycle.
- br_addr  out  32  combinational; branch target.
- stall  out  1  combinational; upstream holds PC, IF/ID and ID/EXE while high.
- dest_out  out  5  registered dest.
- alu_result  out  32  registered result.
- st_val  out  32  registered store data (reg2).
- wb_en_out  out  1  registered write-back enable.
- mem_signal_out  out  2  registered memory controls.

## Operation
- exe_cmd encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL; shift amount is val2[4:0], shifted operand is val1.
  - 1100 MUL: multicycle, low 32 bits of the product.
  - Any other code gives result 0.
- ADD and SUB wrap modulo 2^32. No overflow flag.
- Branch resolution:
  - BEZ is taken when val1 == 0.
  - BNE is taken when val1 != reg2.
  - JMP is always taken.
  - br_addr = pc_in + {val2[29:0], 2'b00} for every branch type, whether or not taken.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: if exe_cmd_in == MUL, load mcand = val1, mplier = val2, acc = 0, cnt = 0, then go to BUSY.
  - BUSY: each cycle, if mplier[0] then acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++. At cnt == 31, after this last iteration, go to DONE.
  - DONE: product = acc. Go to IDLE next cycle.
- stall = (exe_cmd_in == MUL) && (state != DONE).
- EXE/MEM register, each posedge:
  - If stall: load a bubble (dest 0, result 0, st_val 0, wb_en 0, mem_signal 00).
  - Otherwise: load dest_in, the result (acc when state == DONE, else the ALU output), reg2, wb_en_in, mem_signal_in.
- Operands are stable during a stall because upstream holds ID/EXE.

## Timing
- rst: on the next posedge all registered outputs go to 0 and the FSM goes to IDLE, cnt = 0, acc = 0.
- Reset asserted mid-MUL abandons the operation. After reset, stall follows the current exe_cmd_in again.
- Non-MUL instructions: result appears on the EXE/MEM outputs 1 cycle after the instruction is presented.
- MUL presented in cycle 0:
  - stall is high for cycles 0..32 (33 cycles).
  - Cycle 0 is the IDLE load cycle; cycles 1..32 are the BUSY iterations; cycle 33 is DONE, where stall = 0.
  - The product is visible on alu_result after the posedge ending cycle 33, i.e. 34 cycles after presentation.
  - Exactly one non-bubble EXE/MEM entry is produced per MUL.
- Back-to-back MULs: the second is presented in cycle 34, one cycle after DONE, and the FSM restarts from IDLE.
- br_taken and br_addr depend only on the current inputs and are never gated by stall. A branch cannot occupy EXE during a MUL.
- A reset-bubble input (all zeros) decodes to ADD with wb_en 0 and branch_type 00, and is harmless.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all registered outputs 0, stall 0 with exe_cmd 0000.
- ALU sweep:
  - ADD 0xFFFFFFFF + 1 -> 0x00000000.
  - SUB 5 - 7 -> 0xFFFFFFFE.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - NOR 0 with 0 -> 0xFFFFFFFF.
  - Each result appears 1 cycle later.
- Branches:
  - BEZ with val1 = 0, pc_in = 0x100, val2 = 0xFFFFFFFE -> br_taken 1, br_addr 0xF8.
  - BNE with val1 = reg2 = 9 -> br_taken 0.
  - JMP -> br_taken 1.
- MUL: val1 = 0x00010003, val2 = 0x00000007 -> stall high exactly 33 cycles, 33 bubbles on EXE/MEM, then alu_result = 0x00070015 with wb_en_out = 1.
- MUL overflow: 0xFFFFFFFF × 0xFFFFFFFF -> alu_result 0x00000001.
- Reset mid-MUL: assert rst in BUSY at cnt = 10, then present ADD 2+3 -> stall 0, alu_result 5 one cycle later, FSM back in IDLE.
